tcp_rx_ctrl_mc: RTL and testbench
=================================

Name: tcp_rx_ctrl_mc

Overview:
Parametrised, multi-channel successor to the TCP RX pipeline control FSM. It sequences one header at a time through these stages:
- flow-CAM lookup;
- slow-path new-flow setup, with a timeout;
- N independent state/pointer read channels;
- a programmable-latency calculate stage;
- M independent writeback channels;
- scheduler update and header output.

Each channel handshakes independently instead of requiring all ready at once. The block adds drop handling and statistics counters. It sits between the RX header parser and the TCP RX datapath/state memories.

Parameters:
NUM_RD, 4, number of state/pointer read channels (1..8)
NUM_WR, 3, number of writeback channels (1..8)
CALC_CYCLES, 1, cycles spent in CALC (1..15)
SLOW_TO_W, 16, width of slow-path timeout counter; timeout = 2^SLOW_TO_W-1 cycles
CNT_W, 32, statistics counter width

Ports:
clk in 1 clock
rst_n in 1 asynchronous active-low reset
rx_tcp_hdr_val in 1 header valid
rx_hdr_rdy out 1 header ready
read_flow_cam_val out 1 CAM lookup strobe
read_flow_cam_hit in 1 CAM hit, same cycle
store_flowid_cam out 1 capture flow id
ctrl_datap_save_input out 1 datapath captures header
rd_req_val out NUM_RD per-channel read request valid
rd_req_rdy in NUM_RD per-channel read request ready
rd_resp_val in NUM_RD per-channel read response valid
rd_resp_rdy out NUM_RD per-channel read response ready
ctrl_datap_save_flow_state out NUM_RD per-channel capture strobe (= resp handshake)
ctrl_datap_save_calcs out 1 datapath captures calc results
wr_req_val out NUM_WR per-channel writeback valid
wr_req_rdy in NUM_WR per-channel writeback ready
rx_sched_update_val out 1 scheduler update valid
sched_rx_update_rdy in 1 scheduler ready
tcp_rx_dst_hdr_val out 1 header to destination valid
dst_tcp_rx_hdr_rdy in 1 destination ready
slow_path_val out 1 new-flow setup request
slow_path_rdy in 1 slow path accepts
slow_path_done_val in 1 slow path finished
drop_pkt in 1 qualifies slow_path_done_val: discard packet
slow_path_done_rdy out 1 accept done
slow_timeout out 1 one-cycle pulse on slow-path timeout
stat_pkt_cnt out CNT_W packets completed via PKT_OUT
stat_drop_cnt out CNT_W packets dropped or timed out

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE and clears all masks, counters and stats.
  - All outputs are 0 while rst_n is low, including rx_hdr_rdy; it rises the first cycle after deassertion.
- States:
  - IDLE: rx_hdr_rdy=1; save_input=1; store_flowid_cam=1; read_flow_cam_val=rx_tcp_hdr_val. On val: hit→RD, miss→SLOW_REQ.
  - SLOW_REQ: slow_path_val=1; clear timeout counter. On rdy→SLOW_WAIT.
  - SLOW_WAIT: slow_path_done_rdy=1; counter increments each cycle.
    - done_val & ~drop_pkt → RD.
    - done_val & drop_pkt → IDLE; stat_drop_cnt+1.
    - Counter reaches all-ones with no done → IDLE; slow_timeout pulse; stat_drop_cnt+1.
    - done_val in the same cycle as counter saturation: done wins.
  - RD: rd_req_val[i]=~req_done[i]; rd_resp_rdy[i]=~resp_done[i].
    - req_done[i] sets on val&rdy; resp_done[i] sets on val&rdy.
    - A response may arrive in the same cycle as, or before, its request completes; it is accepted either way.
    - Exit when req and resp masks are all ones (including the updates of the current cycle). Clear both masks on exit. Go to CALC.
  - CALC: ctrl_datap_save_calcs=1 in the last of CALC_CYCLES cycles, then WB.
  - WB: wr_req_val[i]=~wr_done[i]; wr_done[i] sets on handshake. Exit when all complete; clear mask; go to SCHED.
  - SCHED: rx_sched_update_val=1. On rdy→OUT.
  - OUT: tcp_rx_dst_hdr_val=1. On rdy→IDLE; stat_pkt_cnt+1.
- Valids never drop before their handshake. Once a channel has handshaken, it is not re-requested.
- Statistics counters wrap modulo 2^CNT_W.
- Single header in flight: rx_hdr_rdy is 0 outside IDLE.

Decomposition:
- Package tcp_rx_ctrl_mc_pkg holds:
  - state enum (4-bit);
  - channel-count limits MAX_RD_CHANS=8 and MAX_WR_CHANS=8.
- Sub-module hs_mask_tracker (parameter WIDTH): tracks per-channel handshake completion.
  - Inputs: val, rdy, clear.
  - Outputs: pending mask and all_done.
  - Instantiated three times: read request, read response, writeback.

Test Plan:
- Hit path, NUM_RD=4, all rdy held 1 → IDLE→RD (1 cycle)→CALC→WB→SCHED→OUT; header out 4+CALC_CYCLES cycles after accept; stat_pkt_cnt=1.
- Staggered readiness: rd_req_rdy bits rise at cycles 1,3,5,2; responses arrive at 6,2(early),7,4 → each valid deasserts after its own handshake; exit CALC on cycle 8.
- Miss, then slow_path_done with drop_pkt=0 after 20 cycles → proceeds to RD without re-accepting the header; drop_pkt=1 variant → IDLE, stat_drop_cnt=1.
- SLOW_TO_W=4, no done → slow_timeout pulse at 15 cycles in SLOW_WAIT; return to IDLE; rx_hdr_rdy=1 next cycle.
- Backpressure in WB: wr_req_rdy=3'b101, then 3'b010 → wr_req_val goes 111→010→000; SCHED entered after the second handshake.
- rst_n asserted mid-WB → all outputs 0 immediately (async); stats cleared; IDLE after release.

Source files
------------

// File: rtl/tcp_rx_ctrl_mc_pkg.sv
// Shared types and limits for the multi-channel TCP RX pipeline controller.
package tcp_rx_ctrl_mc_pkg;

   localparam int unsigned MAX_RD_CHANS = 8;
   localparam int unsigned MAX_WR_CHANS = 8;
   localparam int unsigned STATE_W      = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 4'd0,
      ST_SLOW_REQ  = 4'd1,
      ST_SLOW_WAIT = 4'd2,
      ST_RD        = 4'd3,
      ST_CALC      = 4'd4,
      ST_WB        = 4'd5,
      ST_SCHED     = 4'd6,
      ST_OUT       = 4'd7
   } state_e;

endpackage

// File: rtl/tcp_rx_ctrl_mc_if.sv
// Handshake/bus bundle between the RX controller and its parser, datapath,
// state memories, scheduler, destination and slow path.
interface tcp_rx_ctrl_mc_if #(
   parameter int unsigned NUM_RD = 4,
   parameter int unsigned NUM_WR = 3,
   parameter int unsigned CNT_W  = 32
);
   logic              rx_tcp_hdr_val;
   logic              rx_hdr_rdy;
   logic              read_flow_cam_val;
   logic              read_flow_cam_hit;
   logic              store_flowid_cam;
   logic              ctrl_datap_save_input;
   logic [NUM_RD-1:0] rd_req_val;
   logic [NUM_RD-1:0] rd_req_rdy;
   logic [NUM_RD-1:0] rd_resp_val;
   logic [NUM_RD-1:0] rd_resp_rdy;
   logic [NUM_RD-1:0] ctrl_datap_save_flow_state;
   logic              ctrl_datap_save_calcs;
   logic [NUM_WR-1:0] wr_req_val;
   logic [NUM_WR-1:0] wr_req_rdy;
   logic              rx_sched_update_val;
   logic              sched_rx_update_rdy;
   logic              tcp_rx_dst_hdr_val;
   logic              dst_tcp_rx_hdr_rdy;
   logic              slow_path_val;
   logic              slow_path_rdy;
   logic              slow_path_done_val;
   logic              drop_pkt;
   logic              slow_path_done_rdy;
   logic              slow_timeout;
   logic [CNT_W-1:0]  stat_pkt_cnt;
   logic [CNT_W-1:0]  stat_drop_cnt;

   modport master (
      input  rx_tcp_hdr_val, read_flow_cam_hit, rd_req_rdy, rd_resp_val,
             wr_req_rdy, sched_rx_update_rdy, dst_tcp_rx_hdr_rdy,
             slow_path_rdy, slow_path_done_val, drop_pkt,
      output rx_hdr_rdy, read_flow_cam_val, store_flowid_cam,
             ctrl_datap_save_input, rd_req_val, rd_resp_rdy,
             ctrl_datap_save_flow_state, ctrl_datap_save_calcs, wr_req_val,
             rx_sched_update_val, tcp_rx_dst_hdr_val, slow_path_val,
             slow_path_done_rdy, slow_timeout, stat_pkt_cnt, stat_drop_cnt
   );

   modport slave (
      output rx_tcp_hdr_val, read_flow_cam_hit, rd_req_rdy, rd_resp_val,
             wr_req_rdy, sched_rx_update_rdy, dst_tcp_rx_hdr_rdy,
             slow_path_rdy, slow_path_done_val, drop_pkt,
      input  rx_hdr_rdy, read_flow_cam_val, store_flowid_cam,
             ctrl_datap_save_input, rd_req_val, rd_resp_rdy,
             ctrl_datap_save_flow_state, ctrl_datap_save_calcs, wr_req_val,
             rx_sched_update_val, tcp_rx_dst_hdr_val, slow_path_val,
             slow_path_done_rdy, slow_timeout, stat_pkt_cnt, stat_drop_cnt
   );
endinterface

// File: rtl/tcp_rx_ctrl_mc_hs_mask_tracker.sv
// Per-channel handshake completion tracker: a channel stays pending until its
// val&rdy handshake, and all_done includes handshakes of the current cycle.
module hs_mask_tracker #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_val,
   input  logic [WIDTH-1:0] i_rdy,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_pending,
   output logic             o_all_done_c
);

   logic [WIDTH-1:0] r_pend;
   logic [WIDTH-1:0] w_hs;

   assign w_hs = i_val & i_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '1;
      end else if (i_clear) begin
         r_pend <= '1;
      end else begin
         r_pend <= r_pend & ~w_hs;
      end
   end

   assign o_pending    = r_pend;
   assign o_all_done_c = ~|(r_pend & ~w_hs);

endmodule

// File: rtl/tcp_rx_ctrl_mc.sv
// Multi-channel TCP RX pipeline controller: sequences one header through CAM
// lookup, optional slow-path setup, per-channel reads, calc, writeback, output.
module tcp_rx_ctrl_mc
   import tcp_rx_ctrl_mc_pkg::*;
#(
   parameter int unsigned NUM_RD      = 4,
   parameter int unsigned NUM_WR      = 3,
   parameter int unsigned CALC_CYCLES = 1,
   parameter int unsigned SLOW_TO_W   = 16,
   parameter int unsigned CNT_W       = 32
) (
   input logic              clk,
   input logic              rst_n,
   tcp_rx_ctrl_mc_if.master bus
);

   localparam logic [3:0] S_IDLE      = ST_IDLE;
   localparam logic [3:0] S_SLOW_REQ  = ST_SLOW_REQ;
   localparam logic [3:0] S_SLOW_WAIT = ST_SLOW_WAIT;
   localparam logic [3:0] S_RD        = ST_RD;
   localparam logic [3:0] S_CALC      = ST_CALC;
   localparam logic [3:0] S_WB        = ST_WB;
   localparam logic [3:0] S_SCHED     = ST_SCHED;
   localparam logic [3:0] S_OUT       = ST_OUT;

   // Timeout fires in the cycle the counter would step onto all-ones.
   localparam logic [SLOW_TO_W-1:0] TO_LAST   = {{(SLOW_TO_W-1){1'b1}}, 1'b0};
   localparam logic [3:0]           CALC_LAST = 4'(CALC_CYCLES - 1);

   if (NUM_RD > MAX_RD_CHANS || NUM_WR > MAX_WR_CHANS) begin : g_bad_cfg
      $error("tcp_rx_ctrl_mc: channel count exceeds package limit");
   end

   logic [3:0]           r_state;
   logic [3:0]           w_state_nx;
   logic                 r_active;
   logic [SLOW_TO_W-1:0] r_to_cnt;
   logic [SLOW_TO_W-1:0] w_to_cnt_nx;
   logic [3:0]           r_calc_cnt;
   logic [3:0]           w_calc_cnt_nx;
   logic [CNT_W-1:0]     r_pkt_cnt;
   logic [CNT_W-1:0]     r_drop_cnt;

   logic w_hdr_rdy, w_cam_val, w_save_input, w_save_calcs;
   logic w_sched_val, w_dst_val, w_slow_val, w_done_rdy, w_timeout;
   logic w_rd_clear, w_wr_clear, w_pkt_inc, w_drop_inc;

   logic              w_in_rd, w_in_wb;
   logic [NUM_RD-1:0] w_rdreq_pend, w_rdresp_pend;
   logic [NUM_RD-1:0] w_rd_req_val, w_rd_resp_rdy;
   logic [NUM_WR-1:0] w_wr_pend, w_wr_req_val;
   logic              w_rdreq_all, w_rdresp_all, w_wr_all;

   assign w_in_rd       = (r_state == S_RD);
   assign w_in_wb       = (r_state == S_WB);
   assign w_rd_req_val  = w_in_rd ? w_rdreq_pend  : '0;
   assign w_rd_resp_rdy = w_in_rd ? w_rdresp_pend : '0;
   assign w_wr_req_val  = w_in_wb ? w_wr_pend     : '0;

   hs_mask_tracker #(.WIDTH(NUM_RD)) u_rd_req (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_val        (w_rd_req_val),
      .i_rdy        (bus.rd_req_rdy),
      .i_clear      (w_rd_clear),
      .o_pending    (w_rdreq_pend),
      .o_all_done_c (w_rdreq_all)
   );

   hs_mask_tracker #(.WIDTH(NUM_RD)) u_rd_resp (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_val        (bus.rd_resp_val),
      .i_rdy        (w_rd_resp_rdy),
      .i_clear      (w_rd_clear),
      .o_pending    (w_rdresp_pend),
      .o_all_done_c (w_rdresp_all)
   );

   hs_mask_tracker #(.WIDTH(NUM_WR)) u_wr (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_val        (w_wr_req_val),
      .i_rdy        (bus.wr_req_rdy),
      .i_clear      (w_wr_clear),
      .o_pending    (w_wr_pend),
      .o_all_done_c (w_wr_all)
   );

   // Next-state and strobe decode.
   always_comb begin
      w_state_nx    = r_state;
      w_to_cnt_nx   = r_to_cnt;
      w_calc_cnt_nx = r_calc_cnt;
      w_hdr_rdy     = 1'b0;
      w_cam_val     = 1'b0;
      w_save_input  = 1'b0;
      w_save_calcs  = 1'b0;
      w_sched_val   = 1'b0;
      w_dst_val     = 1'b0;
      w_slow_val    = 1'b0;
      w_done_rdy    = 1'b0;
      w_timeout     = 1'b0;
      w_rd_clear    = 1'b0;
      w_wr_clear    = 1'b0;
      w_pkt_inc     = 1'b0;
      w_drop_inc    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // r_active holds ready low until the first edge after reset.
            w_hdr_rdy    = r_active;
            w_save_input = r_active;
            w_cam_val    = r_active & bus.rx_tcp_hdr_val;
            if (w_cam_val) begin
               w_state_nx = bus.read_flow_cam_hit ? S_RD : S_SLOW_REQ;
            end
         end
         S_SLOW_REQ: begin
            w_slow_val  = 1'b1;
            w_to_cnt_nx = '0;
            if (bus.slow_path_rdy) begin
               w_state_nx = S_SLOW_WAIT;
            end
         end
         S_SLOW_WAIT: begin
            w_done_rdy  = 1'b1;
            w_to_cnt_nx = r_to_cnt + SLOW_TO_W'(1);
            if (bus.slow_path_done_val) begin
               if (bus.drop_pkt) begin
                  w_drop_inc = 1'b1;
                  w_state_nx = S_IDLE;
               end else begin
                  w_state_nx = S_RD;
               end
            end else if (r_to_cnt == TO_LAST) begin
               w_timeout  = 1'b1;
               w_drop_inc = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         S_RD: begin
            if (w_rdreq_all && w_rdresp_all) begin
               w_rd_clear = 1'b1;
               w_state_nx = S_CALC;
            end
         end
         S_CALC: begin
            if (r_calc_cnt == CALC_LAST) begin
               w_save_calcs  = 1'b1;
               w_calc_cnt_nx = '0;
               w_state_nx    = S_WB;
            end else begin
               w_calc_cnt_nx = r_calc_cnt + 4'd1;
            end
         end
         S_WB: begin
            if (w_wr_all) begin
               w_wr_clear = 1'b1;
               w_state_nx = S_SCHED;
            end
         end
         S_SCHED: begin
            w_sched_val = 1'b1;
            if (bus.sched_rx_update_rdy) begin
               w_state_nx = S_OUT;
            end
         end
         S_OUT: begin
            w_dst_val = 1'b1;
            if (bus.dst_tcp_rx_hdr_rdy) begin
               w_pkt_inc  = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_active   <= 1'b0;
         r_to_cnt   <= '0;
         r_calc_cnt <= '0;
         r_pkt_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_active   <= 1'b1;
         r_to_cnt   <= w_to_cnt_nx;
         r_calc_cnt <= w_calc_cnt_nx;
         if (w_pkt_inc) begin
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
         end
         if (w_drop_inc) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.rx_hdr_rdy                 = w_hdr_rdy;
   assign bus.read_flow_cam_val          = w_cam_val;
   assign bus.store_flowid_cam           = w_save_input;
   assign bus.ctrl_datap_save_input      = w_save_input;
   assign bus.rd_req_val                 = w_rd_req_val;
   assign bus.rd_resp_rdy                = w_rd_resp_rdy;
   assign bus.ctrl_datap_save_flow_state = bus.rd_resp_val & w_rd_resp_rdy;
   assign bus.ctrl_datap_save_calcs      = w_save_calcs;
   assign bus.wr_req_val                 = w_wr_req_val;
   assign bus.rx_sched_update_val        = w_sched_val;
   assign bus.tcp_rx_dst_hdr_val         = w_dst_val;
   assign bus.slow_path_val              = w_slow_val;
   assign bus.slow_path_done_rdy         = w_done_rdy;
   assign bus.slow_timeout               = w_timeout;
   assign bus.stat_pkt_cnt               = r_pkt_cnt;
   assign bus.stat_drop_cnt              = r_drop_cnt;

endmodule

// File: tb/tb_tcp_rx_ctrl_mc.sv
// Bench for tcp_rx_ctrl_mc: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the pipeline.
module tb_tcp_rx_ctrl_mc;

   localparam int unsigned NR     = 4;
   localparam int unsigned NW     = 3;
   localparam int unsigned CALC   = 3;
   localparam int unsigned TO_W   = 4;
   localparam int unsigned CW     = 8;
   localparam int unsigned CTL_W  = 4 + 3*NR + 1 + NW + 5;
   localparam int          TO_CYC = (1 << TO_W) - 1;

   localparam int P_IDLE = 0, P_SREQ = 1, P_SWAIT = 2, P_RD = 3;
   localparam int P_CALC = 4, P_WB = 5, P_SCHED = 6, P_OUT = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tcp_rx_ctrl_mc_if #(.NUM_RD(NR), .NUM_WR(NW), .CNT_W(CW)) bus ();

   tcp_rx_ctrl_mc #(
      .NUM_RD(NR), .NUM_WR(NW), .CALC_CYCLES(CALC), .SLOW_TO_W(TO_W), .CNT_W(CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_phase;
   logic        m_active;
   logic [NR-1:0] m_rq, m_rs;
   logic [NW-1:0] m_wr;
   int          m_wait, m_calc;
   logic [CW-1:0] m_pkt, m_drop;

   task automatic model_reset();
      m_phase = P_IDLE; m_active = 1'b0;
      m_rq = '0; m_rs = '0; m_wr = '0;
      m_wait = 0; m_calc = 0; m_pkt = '0; m_drop = '0;
   endtask

   function automatic logic [CTL_W-1:0] model_ctl();
      logic hr = 0, cam = 0, sf = 0, si = 0, sc = 0, sv = 0, dv = 0;
      logic slv = 0, dr = 0, to = 0;
      logic [NR-1:0] rq = '0, rs = '0, sfs = '0;
      logic [NW-1:0] wq = '0;
      if (rst_n) begin
         case (m_phase)
            P_IDLE:  if (m_active) begin
                        hr = 1; sf = 1; si = 1; cam = bus.rx_tcp_hdr_val;
                     end
            P_SREQ:  slv = 1;
            P_SWAIT: begin
                        dr = 1;
                        to = !bus.slow_path_done_val && (m_wait + 1 == TO_CYC);
                     end
            P_RD:    begin rq = ~m_rq; rs = ~m_rs; sfs = rs & bus.rd_resp_val; end
            P_CALC:  sc = (m_calc + 1 == int'(CALC));
            P_WB:    wq = ~m_wr;
            P_SCHED: sv = 1;
            P_OUT:   dv = 1;
            default: ;
         endcase
      end
      return {hr, cam, sf, si, rq, rs, sfs, sc, wq, sv, dv, slv, dr, to};
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      case (m_phase)
         P_IDLE:  if (m_active && bus.rx_tcp_hdr_val)
                     m_phase = bus.read_flow_cam_hit ? P_RD : P_SREQ;
         P_SREQ:  if (bus.slow_path_rdy) begin m_phase = P_SWAIT; m_wait = 0; end
         P_SWAIT: begin
                     m_wait++;
                     if (bus.slow_path_done_val) begin
                        if (bus.drop_pkt) begin m_drop++; m_phase = P_IDLE; end
                        else m_phase = P_RD;
                     end else if (m_wait == TO_CYC) begin
                        m_drop++; m_phase = P_IDLE;
                     end
                  end
         P_RD:    begin
                     m_rq |= bus.rd_req_rdy;
                     m_rs |= bus.rd_resp_val;
                     if (&m_rq && &m_rs) begin
                        m_rq = '0; m_rs = '0; m_calc = 0; m_phase = P_CALC;
                     end
                  end
         P_CALC:  begin
                     m_calc++;
                     if (m_calc == int'(CALC)) m_phase = P_WB;
                  end
         P_WB:    begin
                     m_wr |= bus.wr_req_rdy;
                     if (&m_wr) begin m_wr = '0; m_phase = P_SCHED; end
                  end
         P_SCHED: if (bus.sched_rx_update_rdy) m_phase = P_OUT;
         P_OUT:   if (bus.dst_tcp_rx_hdr_rdy) begin m_pkt++; m_phase = P_IDLE; end
         default: m_phase = P_IDLE;
      endcase
      m_active = 1'b1;
   endtask

   logic [CTL_W-1:0] act_ctl;
   assign act_ctl = {bus.rx_hdr_rdy, bus.read_flow_cam_val, bus.store_flowid_cam,
                     bus.ctrl_datap_save_input, bus.rd_req_val, bus.rd_resp_rdy,
                     bus.ctrl_datap_save_flow_state, bus.ctrl_datap_save_calcs,
                     bus.wr_req_val, bus.rx_sched_update_val, bus.tcp_rx_dst_hdr_val,
                     bus.slow_path_val, bus.slow_path_done_rdy, bus.slow_timeout};

   // Per-cycle compare against the model, sampled mid-cycle.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) model_reset();
         chk("ctl", 64'(act_ctl), 64'(model_ctl()));
         chk("stats", 64'({bus.stat_pkt_cnt, bus.stat_drop_cnt}), 64'({m_pkt, m_drop}));
         @(posedge clk);
         model_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic clr_inputs();
      bus.rx_tcp_hdr_val = 0; bus.read_flow_cam_hit = 0;
      bus.rd_req_rdy = '0; bus.rd_resp_val = '0; bus.wr_req_rdy = '0;
      bus.sched_rx_update_rdy = 0; bus.dst_tcp_rx_hdr_rdy = 0;
      bus.slow_path_rdy = 0; bus.slow_path_done_val = 0; bus.drop_pkt = 0;
   endtask

   task automatic all_ready();
      bus.rd_req_rdy = '1; bus.rd_resp_val = '1; bus.wr_req_rdy = '1;
      bus.sched_rx_update_rdy = 1; bus.dst_tcp_rx_hdr_rdy = 1;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 40 && !bus.rx_hdr_rdy; i++) begin
         @(negedge clk);
         #3;
      end
      chk(name, 64'(bus.rx_hdr_rdy), 64'(1));
   endtask

   task automatic wait_wb(input string name);
      for (int i = 0; i < 40 && bus.wr_req_val == '0; i++) begin
         @(negedge clk);
         bus.rx_tcp_hdr_val = 0;
         #3;
      end
      chk(name, 64'(bus.wr_req_val), 64'(3'b111));
   endtask

   int n;
   int pcts[3] = '{0, 10, 40};

   initial begin
      clr_inputs();
      repeat (2) @(negedge clk);
      #3 chk("reset_hdr_rdy", 64'(bus.rx_hdr_rdy), 64'(0));
      @(negedge clk);
      rst_n = 1;
      #3 chk("release_before_edge", 64'(bus.rx_hdr_rdy), 64'(0));
      @(negedge clk);
      #3 chk("release_after_edge", 64'(bus.rx_hdr_rdy), 64'(1));

      // Hit path, everything ready except destination.
      @(negedge clk);
      all_ready();
      bus.dst_tcp_rx_hdr_rdy = 0;
      bus.rx_tcp_hdr_val = 1; bus.read_flow_cam_hit = 1;
      #3 chk("cam_strobe", 64'(bus.read_flow_cam_val), 64'(1));
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin
         @(negedge clk);
         bus.rx_tcp_hdr_val = 0;
         #3 if (bus.tcp_rx_dst_hdr_val) n = i;
      end
      chk("hit_latency", 64'(n), 64'(4 + CALC));
      @(negedge clk);
      bus.dst_tcp_rx_hdr_rdy = 1;
      @(negedge clk);
      #3 chk("hit_pkt_cnt", 64'(bus.stat_pkt_cnt), 64'(1));
      chk("hit_back_idle", 64'(bus.rx_hdr_rdy), 64'(1));

      // Miss with no completion: timeout after 15 wait cycles.
      clr_inputs();
      bus.rx_tcp_hdr_val = 1;
      @(negedge clk);
      bus.rx_tcp_hdr_val = 0; bus.slow_path_rdy = 1;
      #3 chk("slow_req", 64'(bus.slow_path_val), 64'(1));
      n = 0;
      for (int i = 1; i <= 30 && n == 0; i++) begin
         @(negedge clk);
         bus.slow_path_rdy = 0;
         #3 if (bus.slow_timeout) n = i;
      end
      chk("timeout_cycle", 64'(n), 64'(TO_CYC));
      @(negedge clk);
      #3 chk("timeout_idle", 64'(bus.rx_hdr_rdy), 64'(1));
      chk("timeout_drop_cnt", 64'(bus.stat_drop_cnt), 64'(1));

      // Miss then done with drop.
      bus.rx_tcp_hdr_val = 1;
      @(negedge clk);
      bus.rx_tcp_hdr_val = 0; bus.slow_path_rdy = 1;
      repeat (4) begin @(negedge clk); bus.slow_path_rdy = 0; end
      @(negedge clk);
      bus.slow_path_done_val = 1; bus.drop_pkt = 1;
      @(negedge clk);
      bus.slow_path_done_val = 0; bus.drop_pkt = 0;
      #3 chk("drop_cnt", 64'(bus.stat_drop_cnt), 64'(2));
      chk("drop_idle", 64'(bus.rx_hdr_rdy), 64'(1));

      // Miss then done without drop: continues to reads.
      bus.rx_tcp_hdr_val = 1;
      @(negedge clk);
      bus.rx_tcp_hdr_val = 0; bus.slow_path_rdy = 1;
      repeat (4) begin @(negedge clk); bus.slow_path_rdy = 0; end
      @(negedge clk);
      bus.slow_path_done_val = 1;
      @(negedge clk);
      bus.slow_path_done_val = 0;
      #3 chk("slow_to_rd", 64'(bus.rd_req_val), 64'(4'hF));
      chk("slow_no_reaccept", 64'(bus.rx_hdr_rdy), 64'(0));
      all_ready();
      wait_idle("slow_done_idle");
      chk("slow_pkt_cnt", 64'(bus.stat_pkt_cnt), 64'(2));

      // Writeback backpressure.
      clr_inputs();
      bus.rd_req_rdy = '1; bus.rd_resp_val = '1;
      bus.sched_rx_update_rdy = 0; bus.dst_tcp_rx_hdr_rdy = 1;
      bus.rx_tcp_hdr_val = 1; bus.read_flow_cam_hit = 1;
      wait_wb("wb_entry");
      @(negedge clk);
      bus.wr_req_rdy = 3'b101;
      #3 chk("wb_before_hs", 64'(bus.wr_req_val), 64'(3'b111));
      @(negedge clk);
      bus.wr_req_rdy = 3'b010;
      #3 chk("wb_after_first", 64'(bus.wr_req_val), 64'(3'b010));
      @(negedge clk);
      bus.wr_req_rdy = 3'b000;
      #3 chk("wb_after_second", 64'(bus.wr_req_val), 64'(3'b000));
      chk("wb_to_sched", 64'(bus.rx_sched_update_val), 64'(1));
      bus.sched_rx_update_rdy = 1;
      wait_idle("wb_idle");
      chk("wb_pkt_cnt", 64'(bus.stat_pkt_cnt), 64'(3));

      // Asynchronous reset in the middle of writeback.
      clr_inputs();
      bus.rd_req_rdy = '1; bus.rd_resp_val = '1;
      bus.rx_tcp_hdr_val = 1; bus.read_flow_cam_hit = 1;
      wait_wb("rst_wb_entry");
      @(negedge clk);
      rst_n = 0;
      #1 chk("rst_wr_val", 64'(bus.wr_req_val), 64'(0));
      chk("rst_pkt_cnt", 64'(bus.stat_pkt_cnt), 64'(0));
      chk("rst_drop_cnt", 64'(bus.stat_drop_cnt), 64'(0));
      chk("rst_hdr_rdy", 64'(bus.rx_hdr_rdy), 64'(0));
      @(negedge clk);
      clr_inputs();
      rst_n = 1;
      @(negedge clk);
      #3 chk("rst_release_idle", 64'(bus.rx_hdr_rdy), 64'(1));

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = !(c >= 1500 && c < 1502);
         bus.rx_tcp_hdr_val      = ($urandom % 4) == 0;
         bus.read_flow_cam_hit   = $urandom % 2;
         bus.rd_req_rdy          = NR'($urandom);
         bus.rd_resp_val         = NR'($urandom);
         bus.wr_req_rdy          = NW'($urandom);
         bus.sched_rx_update_rdy = ($urandom % 3) != 0;
         bus.dst_tcp_rx_hdr_rdy  = ($urandom % 3) != 0;
         bus.slow_path_rdy       = $urandom % 2;
         bus.slow_path_done_val  = $urandom_range(0, 99) < pcts[(c / 250) % 3];
         bus.drop_pkt            = ($urandom % 3) == 0;
      end

      @(negedge clk);
      clr_inputs();
      repeat (2) @(negedge clk);
      #4 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
